// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read-side logic.
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int GAP_WIDTH  = 8;
  localparam int CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    GAP
  } rd_state_t;

  // A new word may be started only while enabled and the FIFO holds data.
  function automatic logic pop_ok(input logic enable, input logic empty);
    return enable && !empty;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read port plus transmitter valid/ready channel, as seen by the read sequencer.
interface fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) ();

  logic                  empty;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  // Sequencer side: pops the FIFO and drives the transmitter.
  modport master (
    input  empty,
    input  r_data,
    input  tx_ready,
    output r_en,
    output tx_data,
    output tx_valid
  );

  // FIFO/transmitter side.
  modport slave (
    output empty,
    output r_data,
    output tx_ready,
    input  r_en,
    input  tx_data,
    input  tx_valid
  );

endinterface

// File: rtl/fifo_gap_timer.sv
// Inter-frame gap down-counter; done flags the last gap cycle.
module fifo_gap_timer #(
  parameter int GAP_WIDTH = fifo_pkg::GAP_WIDTH
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 load,
  input  logic [GAP_WIDTH-1:0] load_val,
  input  logic                 tick,
  output logic                 done
);

  localparam logic [GAP_WIDTH-1:0] ONE = 1;

  logic [GAP_WIDTH-1:0] count;

  // Load on SEND exit, otherwise count down once per GAP cycle, never below zero.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - ONE;
    end
  end

  // Reading 1 marks the final gap cycle; a zero count also releases so GAP can never stall.
  assign done = (count <= ONE);

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side sequencer: pops one FIFO word at a time, hands it to uart_tx over
// valid/ready, inserts a programmable gap and counts delivered words.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int GAP_WIDTH  = fifo_pkg::GAP_WIDTH,
  parameter int CNT_WIDTH  = fifo_pkg::CNT_WIDTH
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 enable,
  input  logic [GAP_WIDTH-1:0] gap_cycles,
  fifo_rd_ctrl_if.master       bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] byte_count
);

  import fifo_pkg::*;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  rd_state_t             state_q;
  rd_state_t             state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  handshake;
  logic                  gap_load;
  logic                  gap_tick;
  logic                  gap_done;

  fifo_gap_timer #(
    .GAP_WIDTH (GAP_WIDTH)
  ) u_gap_timer (
    .r_clk    (r_clk),
    .r_rst    (r_rst),
    .load     (gap_load),
    .load_val (gap_cycles),
    .tick     (gap_tick),
    .done     (gap_done)
  );

  assign handshake   = (state_q == SEND) && bus.tx_ready;
  assign busy        = (state_q != IDLE);
  assign bus.tx_data = data_q;

  // State register.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; enable/empty are only looked at in IDLE and on SEND/GAP exit.
  always_comb begin
    state_d      = state_q;
    bus.r_en     = 1'b0;
    bus.tx_valid = 1'b0;
    gap_load     = 1'b0;
    gap_tick     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop_ok(enable, bus.empty)) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        bus.r_en = 1'b1;
        state_d  = LOAD;
      end
      LOAD: begin
        state_d = SEND;
      end
      SEND: begin
        bus.tx_valid = 1'b1;
        if (bus.tx_ready) begin
          if (gap_cycles != '0) begin
            gap_load = 1'b1;
            state_d  = GAP;
          end else if (pop_ok(enable, bus.empty)) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gap_tick = 1'b1;
        if (gap_done) begin
          state_d = pop_ok(enable, bus.empty) ? FETCH : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the popped word in LOAD; it stays put through SEND so backpressure cannot disturb it.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      data_q <= '0;
    end else if (state_q == LOAD) begin
      data_q <= bus.r_data;
    end
  end

  // Delivered-word counter, wraps silently.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      byte_count <= '0;
    end else if (handshake) begin
      byte_count <= byte_count + CNT_ONE;
    end
  end

endmodule
